// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between the fetch and data ports.
// Optional ARB_STATS_EN adds grant/conflict statistics counters.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_addr,
   input  logic [1:0]  if_command,
   output logic        if_grant,
   output logic        if_data_valid,
   output logic [31:0] if_data,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [1:0]  dm_command,
   output logic        dm_grant,
   output logic        dm_data_valid,
   output logic [31:0] dm_rdata,
   output logic [31:0] proc2mem_addr,
   output logic [31:0] proc2mem_data,
   output logic [1:0]  proc2mem_command,
   input  logic [3:0]  mem2proc_response,
   input  logic [31:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic        err_tag,
   output logic [31:0] stat_if_grants,
   output logic [31:0] stat_dm_grants,
   output logic [31:0] stat_conflicts
);

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

   logic [15:0]   tbl_v;
   logic [15:0]   tbl_o;
   logic [3:0]    outst;
   logic [SW-1:0] starve;

   logic if_ld, dm_ld, dm_st, full;
   logic if_el, dm_el, if_win, dm_win;
   logic alloc, hit, re_alloc;

   assign if_ld = (if_command == CMD_LOAD);
   assign dm_ld = (dm_command == CMD_LOAD);
   assign dm_st = (dm_command == CMD_STORE);
   assign full  = (outst == OUT_MAX);
   assign if_el = if_ld & ~full;
   assign dm_el = dm_st | (dm_ld & ~full);

   // A starved fetch overrides the normal data-port priority.
   assign if_win = rst_n & if_el & ((starve == STARVE_MAX) | ~dm_el);
   assign dm_win = rst_n & dm_el & ~if_win;

   assign if_grant = if_win & (|mem2proc_response);
   assign dm_grant = dm_win & (|mem2proc_response);

   always_comb begin
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_command = CMD_NONE;
      unique case (1'b1)
         if_win: begin
            proc2mem_addr    = if_addr;
            proc2mem_command = CMD_LOAD;
         end
         dm_win: begin
            proc2mem_addr    = dm_addr;
            proc2mem_data    = dm_wdata;
            proc2mem_command = dm_command;
         end
         default: ;
      endcase
   end

   assign alloc = if_grant | (dm_grant & dm_ld);
   assign hit   = (|mem2proc_tag) & tbl_v[mem2proc_tag];
   // Overwriting a live entry must not count as a new load in flight.
   assign re_alloc = alloc & tbl_v[mem2proc_response]
                   & ~(hit & (mem2proc_tag == mem2proc_response));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_v         <= '0;
         tbl_o         <= '0;
         outst         <= '0;
         starve        <= '0;
         err_tag       <= 1'b0;
         if_data_valid <= 1'b0;
         dm_data_valid <= 1'b0;
         if_data       <= '0;
         dm_rdata      <= '0;
      end else begin
         if_data_valid <= hit & ~tbl_o[mem2proc_tag];
         dm_data_valid <= hit & tbl_o[mem2proc_tag];
         if (hit & ~tbl_o[mem2proc_tag]) if_data  <= mem2proc_data;
         if (hit & tbl_o[mem2proc_tag])  dm_rdata <= mem2proc_data;
         if (hit) tbl_v[mem2proc_tag] <= 1'b0;
         if ((|mem2proc_tag) & ~hit) err_tag <= 1'b1;
         if (alloc) begin
            tbl_v[mem2proc_response] <= 1'b1;
            tbl_o[mem2proc_response] <= dm_grant;
         end
         if (re_alloc) err_tag <= 1'b1;
         unique case ({alloc & ~re_alloc, hit})
            2'b10:   outst <= outst + 4'd1;
            2'b01:   outst <= outst - 4'd1;
            default: outst <= outst;
         endcase
         if (if_ld & ~if_grant) begin
            if (starve != STARVE_MAX) starve <= starve + 1'b1;
         end else begin
            starve <= '0;
         end
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_if_grants <= '0;
         stat_dm_grants <= '0;
         stat_conflicts <= '0;
      end else begin
         if (if_grant) stat_if_grants <= stat_if_grants + 32'd1;
         if (dm_grant) stat_dm_grants <= stat_dm_grants + 32'd1;
         if (if_ld & (dm_ld | dm_st))
            stat_conflicts <= stat_conflicts + 32'd1;
      end
   end
`else
   assign stat_if_grants = '0;
   assign stat_dm_grants = '0;
   assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a tag-table model.
module tb_mem_port_arbiter;
   localparam int MAXO = 8;
   localparam int LIM  = 4;

   logic        clk = 0;
   logic        rst_n = 0;
   logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem2proc_data = 0;
   logic [1:0]  if_command = 0, dm_command = 0;
   logic [3:0]  mem2proc_response = 0, mem2proc_tag = 0;
   logic        if_grant, if_data_valid, dm_grant, dm_data_valid, err_tag;
   logic [31:0] if_data, dm_rdata, proc2mem_addr, proc2mem_data;
   logic [1:0]  proc2mem_command;
   logic [31:0] stat_if_grants, stat_dm_grants, stat_conflicts;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_addr(if_addr), .if_command(if_command), .if_grant(if_grant),
      .if_data_valid(if_data_valid), .if_data(if_data),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_command(dm_command),
      .dm_grant(dm_grant), .dm_data_valid(dm_data_valid), .dm_rdata(dm_rdata),
      .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
      .proc2mem_command(proc2mem_command),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag), .err_tag(err_tag),
      .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants),
      .stat_conflicts(stat_conflicts)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   // Reference model: who owns each tag, and what was promised to whom.
   bit          mv[16];
   bit          mo[16];
   int          m_out, m_starve, m_win;
   bit          m_err;
   bit          e_if_dv, e_dm_dv;
   logic [31:0] e_if_d, e_dm_d, s_if, s_dm, s_cf;

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", t, o, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin mv[i] = 0; mo[i] = 0; end
      m_out = 0; m_starve = 0; m_err = 0;
      e_if_dv = 0; e_dm_dv = 0; e_if_d = 0; e_dm_d = 0;
      s_if = 0; s_dm = 0; s_cf = 0;
   endtask

   task automatic check_regs();
      chk("if_data_valid", 32'(if_data_valid), 32'(e_if_dv));
      chk("dm_data_valid", 32'(dm_data_valid), 32'(e_dm_dv));
      chk("if_data", if_data, e_if_d);
      chk("dm_rdata", dm_rdata, e_dm_d);
      chk("err_tag", 32'(err_tag), 32'(m_err));
`ifdef ARB_STATS_EN
      chk("stat_if", stat_if_grants, s_if);
      chk("stat_dm", stat_dm_grants, s_dm);
      chk("stat_cf", stat_conflicts, s_cf);
`else
      chk("stat_if", stat_if_grants, 32'd0);
      chk("stat_dm", stat_dm_grants, 32'd0);
      chk("stat_cf", stat_conflicts, 32'd0);
`endif
   endtask

   // Drive one cycle's inputs and check everything visible before the edge.
   task automatic drive(input logic [1:0] ic, input logic [31:0] ia,
                        input logic [1:0] dc, input logic [31:0] da,
                        input logic [31:0] dw, input logic [3:0] rsp,
                        input logic [3:0] tg, input logic [31:0] rd);
      bit if_ok, dm_ok, g;
      logic [1:0]  e_cmd;
      logic [31:0] e_addr, e_data;
      if_command = ic; if_addr = ia; dm_command = dc; dm_addr = da;
      dm_wdata = dw; mem2proc_response = rsp; mem2proc_tag = tg;
      mem2proc_data = rd;
      #1;
      if_ok = (ic == 1) && (m_out < MAXO);
      dm_ok = (dc == 2) || ((dc == 1) && (m_out < MAXO));
      if (if_ok && (m_starve == LIM || !dm_ok)) m_win = 1;
      else if (dm_ok) m_win = 2;
      else m_win = 0;
      g = (m_win != 0) && (rsp != 0);
      e_cmd  = (m_win == 1) ? 2'd1 : (m_win == 2) ? dc : 2'd0;
      e_addr = (m_win == 1) ? ia : (m_win == 2) ? da : 32'd0;
      e_data = (m_win == 2) ? dw : 32'd0;
      chk("proc2mem_command", 32'(proc2mem_command), 32'(e_cmd));
      chk("proc2mem_addr", proc2mem_addr, e_addr);
      chk("proc2mem_data", proc2mem_data, e_data);
      chk("if_grant", 32'(if_grant), 32'(g && m_win == 1));
      chk("dm_grant", 32'(dm_grant), 32'(g && m_win == 2));
      check_regs();
   endtask

   task automatic step();
      bit g;
      @(posedge clk);
      g = (m_win != 0) && (mem2proc_response != 0);
      e_if_dv = 0; e_dm_dv = 0;
      if (mem2proc_tag != 0) begin
         if (mv[mem2proc_tag]) begin
            if (mo[mem2proc_tag]) begin e_dm_dv = 1; e_dm_d = mem2proc_data; end
            else begin e_if_dv = 1; e_if_d = mem2proc_data; end
            mv[mem2proc_tag] = 0;
            m_out--;
         end else m_err = 1;
      end
      if (g && (m_win == 1 || dm_command == 1)) begin
         if (mv[mem2proc_response]) m_err = 1;
         else m_out++;
         mv[mem2proc_response] = 1;
         mo[mem2proc_response] = (m_win == 2);
      end
      if (if_command == 1 && !(g && m_win == 1))
         m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else m_starve = 0;
      if (g && m_win == 1) s_if++;
      if (g && m_win == 2) s_dm++;
      if (if_command == 1 && (dm_command == 1 || dm_command == 2)) s_cf++;
      @(negedge clk);
   endtask

   task automatic cyc(input logic [1:0] ic, input logic [31:0] ia,
                      input logic [1:0] dc, input logic [31:0] da,
                      input logic [31:0] dw, input logic [3:0] rsp,
                      input logic [3:0] tg, input logic [31:0] rd);
      drive(ic, ia, dc, da, dw, rsp, tg, rd);
      step();
   endtask

   // Reset with the request inputs left as they are.
   task automatic do_reset();
      rst_n = 0;
      model_reset();
      #1;
      chk("rst_cmd", 32'(proc2mem_command), 32'd0);
      chk("rst_addr", proc2mem_addr, 32'd0);
      chk("rst_if_grant", 32'(if_grant), 32'd0);
      chk("rst_dm_grant", 32'(dm_grant), 32'd0);
      check_regs();
      @(posedge clk); @(negedge clk);
      rst_n = 1;
   endtask

   function automatic logic [3:0] pick_free(input logic [3:0] avoid);
      logic [3:0] t;
      t = 4'($urandom_range(1, 15));
      for (int k = 0; k < 64 && (mv[t] || t == avoid); k++)
         t = 4'($urandom_range(1, 15));
      return (mv[t] || t == avoid) ? 4'd0 : t;
   endfunction

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Single fetch and its returned instruction.
      cyc(1, 32'h100, 0, 0, 0, 3, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 3, 32'h6f);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_if_dv", 32'(if_data_valid), 32'd1);
      chk("t1_if_data", if_data, 32'h6f);
      step();

      // Data port beats fetch.
      drive(1, 32'h100, 1, 32'h2000, 0, 1, 0, 0);
      chk("t2_dm_grant", 32'(dm_grant), 32'd1);
      chk("t2_addr", proc2mem_addr, 32'h2000);
      step();
      cyc(0, 0, 0, 0, 0, 0, 1, 32'hbeef);

      // Starvation: fetch must win on the fifth contended cycle.
      for (int i = 0; i < 4; i++) cyc(1, 32'h104, 2, 32'h40, i, 5, 0, 0);
      drive(1, 32'h104, 2, 32'h40, 9, 5, 0, 0);
      chk("t3_if_grant", 32'(if_grant), 32'd1);
      step();
      drive(1, 32'h108, 2, 32'h40, 9, 6, 0, 0);
      chk("t3_dm_after", 32'(dm_grant), 32'd1);
      step();

      // Load hold-off at the outstanding limit.
      do_reset();
      for (int i = 1; i <= MAXO; i++) cyc(0, 0, 1, 32'h3000 + i, 0, 4'(i), 0, 0);
      drive(1, 32'h300, 0, 0, 0, 9, 0, 0);
      chk("t4_held", 32'(proc2mem_command), 32'd0);
      step();
      drive(1, 32'h300, 2, 32'h44, 32'h55, 9, 0, 0);
      chk("t4_store", 32'(proc2mem_command), 32'd2);
      step();
      cyc(1, 32'h300, 0, 0, 0, 0, 1, 32'h77);
      drive(1, 32'h300, 0, 0, 0, 9, 0, 0);
      chk("t4_resume", 32'(proc2mem_command), 32'd1);
      step();

      // Return of a tag nobody owns.
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 7, 32'h1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_err", 32'(err_tag), 32'd1);

      // Reset mid-burst forgets the owner of tag 2.
      do_reset();
      cyc(1, 32'h200, 0, 0, 0, 2, 0, 0);
      cyc(1, 32'h204, 1, 32'h500, 0, 4, 0, 0);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 2, 32'h9);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_err", 32'(err_tag), 32'd1);

      // Random traffic.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [3:0] tg, rsp;
         logic [3:0] live[$];
         live.delete();
         for (int t = 1; t < 16; t++) if (mv[t]) live.push_back(4'(t));
         tg = (live.size() != 0 && $urandom_range(0, 9) < 4)
            ? live[$urandom_range(0, live.size() - 1)] : 4'd0;
         rsp = ($urandom_range(0, 9) < 7) ? pick_free(tg) : 4'd0;
         cyc(2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 2)),
             $urandom, $urandom, rsp, tg, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
